// File: rtl/rob.sv
// ---------------------------------------------------------------------------
// rob -- reorder buffer between rename (rf) and retirement.
//
// Instructions arrive in program order from rf and are given the tail slot as
// their tag. Results come back out of order on the CDB and are marked ready.
// The head entry retires, at most one per cycle, once it is ready. A retiring
// entry that carries an exception also flushes the whole buffer and
// broadcasts the redirect PC.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; 0 freezes all state
//   *_from_rf / *_to_rf      dispatch offer, allocated tag, full flag
//   *_from_cdb               result writeback (tag, value, exception, target)
//   query_tag1/2, ready1/2,
//   value1/2                 combinational operand lookup for rf
//   is_finish_to_rf, rd_to_rf, data_to_rf, tag_to_rf_commit
//                            registered retire interface (pulse + data)
//   is_store_to_slb          registered pulse: head store may commit
//   is_exception_to_all,
//   pc_to_iq                 registered flush pulse and redirect PC
//
// Dispatch handshake: rf offers an instruction whenever is_empty_from_rf=0;
// the offer is accepted at the clock edge exactly when is_full_to_rf=0,
// rdy=1 and no flush retires in that cycle. Otherwise rf holds the offer.
// ---------------------------------------------------------------------------
module rob #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             is_empty_from_rf,
    input  logic [4:0]       rd_from_rf,
    input  logic [31:0]      pc_from_rf,
    input  logic             is_store_from_rf,
    output logic [TAG_W-1:0] tag_to_rf,
    output logic             is_full_to_rf,
    input  logic             is_valid_from_cdb,
    input  logic [TAG_W-1:0] tag_from_cdb,
    input  logic [31:0]      data_from_cdb,
    input  logic             is_exception_from_cdb,
    input  logic [31:0]      target_from_cdb,
    input  logic [TAG_W-1:0] query_tag1,
    input  logic [TAG_W-1:0] query_tag2,
    output logic             ready1,
    output logic             ready2,
    output logic [31:0]      value1,
    output logic [31:0]      value2,
    output logic             is_finish_to_rf,
    output logic [4:0]       rd_to_rf,
    output logic [31:0]      data_to_rf,
    output logic [TAG_W-1:0] tag_to_rf_commit,
    output logic             is_store_to_slb,
    output logic             is_exception_to_all,
    output logic [31:0]      pc_to_iq
);

    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

    // Per-entry state
    logic [DEPTH-1:0] busy_q,  busy_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] exc_q,   exc_d;
    logic [DEPTH-1:0] store_q, store_d;
    logic [4:0]       rd_q     [DEPTH];
    logic [4:0]       rd_d     [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      pc_d     [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      value_d  [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];

    logic [TAG_W-1:0] head_q,  head_d;
    logic [TAG_W-1:0] tail_q,  tail_d;
    logic [TAG_W:0]   count_q, count_d;

    // Registered outputs
    logic             finish_q,     finish_d;
    logic [4:0]       rd_out_q,     rd_out_d;
    logic [31:0]      data_out_q,   data_out_d;
    logic [TAG_W-1:0] tag_commit_q, tag_commit_d;
    logic             store_out_q,  store_out_d;
    logic             flush_out_q,  flush_out_d;
    logic [31:0]      pc_iq_q,      pc_iq_d;

    logic full, commit, flush, dispatch;

    assign full     = (count_q == FULL_COUNT);
    // Commit decisions use only registered state, so a same-cycle writeback
    // to the head is seen one edge later.
    assign commit   = busy_q[head_q] & ready_q[head_q];
    assign flush    = commit & exc_q[head_q];
    assign dispatch = !is_empty_from_rf && !full && !flush;

    assign tag_to_rf     = tail_q;
    assign is_full_to_rf = full;

    assign ready1 = busy_q[query_tag1] & ready_q[query_tag1];
    assign ready2 = busy_q[query_tag2] & ready_q[query_tag2];
    assign value1 = value_q[query_tag1];
    assign value2 = value_q[query_tag2];

    assign is_finish_to_rf     = finish_q;
    assign rd_to_rf            = rd_out_q;
    assign data_to_rf          = data_out_q;
    assign tag_to_rf_commit    = tag_commit_q;
    assign is_store_to_slb     = store_out_q;
    assign is_exception_to_all = flush_out_q;
    assign pc_to_iq            = pc_iq_q;

    // The per-entry PC is kept for debug visibility only; nothing in the
    // retire path consumes it.
    logic [31:0] unused_pc_fold;
    always_comb begin
        unused_pc_fold = '0;
        for (int i = 0; i < DEPTH; i++) unused_pc_fold = unused_pc_fold ^ pc_q[i];
    end

    always_comb begin
        busy_d       = busy_q;
        ready_d      = ready_q;
        exc_d        = exc_q;
        store_d      = store_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        value_d      = value_q;
        target_d     = target_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        finish_d     = 1'b0;
        store_out_d  = 1'b0;
        flush_out_d  = 1'b0;
        rd_out_d     = rd_out_q;
        data_out_d   = data_out_q;
        tag_commit_d = tag_commit_q;
        pc_iq_d      = pc_iq_q;

        if (rdy) begin
            if (is_valid_from_cdb && busy_q[tag_from_cdb]) begin
                ready_d[tag_from_cdb]  = 1'b1;
                value_d[tag_from_cdb]  = data_from_cdb;
                exc_d[tag_from_cdb]    = is_exception_from_cdb;
                target_d[tag_from_cdb] = target_from_cdb;
            end

            if (commit) begin
                tag_commit_d = head_q;
                data_out_d   = value_q[head_q];
                if (store_q[head_q]) begin
                    store_out_d = 1'b1;
                end else if (rd_q[head_q] != 5'd0) begin
                    finish_d = 1'b1;
                    rd_out_d = rd_q[head_q];
                end
                busy_d[head_q] = 1'b0;
                head_d         = head_q + TAG_ONE;
            end

            if (dispatch) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                exc_d[tail_q]   = 1'b0;
                store_d[tail_q] = is_store_from_rf;
                rd_d[tail_q]    = rd_from_rf;
                pc_d[tail_q]    = pc_from_rf;
                tail_d          = tail_q + TAG_ONE;
            end

            if (dispatch && !commit)      count_d = count_q + CNT_ONE;
            else if (!dispatch && commit) count_d = count_q - CNT_ONE;

            // Flush overrides everything written above except the retire
            // outputs of the excepting head itself.
            if (flush) begin
                flush_out_d = 1'b1;
                pc_iq_d     = target_q[head_q];
                busy_d      = '0;
                head_d      = '0;
                tail_d      = '0;
                count_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            ready_q      <= '0;
            exc_q        <= '0;
            store_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]     <= '0;
                pc_q[i]     <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            finish_q     <= 1'b0;
            rd_out_q     <= '0;
            data_out_q   <= '0;
            tag_commit_q <= '0;
            store_out_q  <= 1'b0;
            flush_out_q  <= 1'b0;
            pc_iq_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            exc_q        <= exc_d;
            store_q      <= store_d;
            rd_q         <= rd_d;
            pc_q         <= pc_d;
            value_q      <= value_d;
            target_q     <= target_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            finish_q     <= finish_d;
            rd_out_q     <= rd_out_d;
            data_out_q   <= data_out_d;
            tag_commit_q <= tag_commit_d;
            store_out_q  <= store_out_d;
            flush_out_q  <= flush_out_d;
            pc_iq_q      <= pc_iq_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// ---------------------------------------------------------------------------
// tb_rob -- directed self-checking bench for the reorder buffer.
// Each scenario task drives stimulus and compares outputs against values
// worked out by hand from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_rob;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        is_empty_from_rf;
    logic [4:0]  rd_from_rf;
    logic [31:0] pc_from_rf;
    logic        is_store_from_rf;
    logic [3:0]  tag_to_rf;
    logic        is_full_to_rf;
    logic        is_valid_from_cdb;
    logic [3:0]  tag_from_cdb;
    logic [31:0] data_from_cdb;
    logic        is_exception_from_cdb;
    logic [31:0] target_from_cdb;
    logic [3:0]  query_tag1;
    logic [3:0]  query_tag2;
    logic        ready1;
    logic        ready2;
    logic [31:0] value1;
    logic [31:0] value2;
    logic        is_finish_to_rf;
    logic [4:0]  rd_to_rf;
    logic [31:0] data_to_rf;
    logic [3:0]  tag_to_rf_commit;
    logic        is_store_to_slb;
    logic        is_exception_to_all;
    logic [31:0] pc_to_iq;

    int n_checks = 0;
    int n_pass   = 0;

    rob #(.DEPTH(16), .TAG_W(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .is_empty_from_rf      (is_empty_from_rf),
        .rd_from_rf            (rd_from_rf),
        .pc_from_rf            (pc_from_rf),
        .is_store_from_rf      (is_store_from_rf),
        .tag_to_rf             (tag_to_rf),
        .is_full_to_rf         (is_full_to_rf),
        .is_valid_from_cdb     (is_valid_from_cdb),
        .tag_from_cdb          (tag_from_cdb),
        .data_from_cdb         (data_from_cdb),
        .is_exception_from_cdb (is_exception_from_cdb),
        .target_from_cdb       (target_from_cdb),
        .query_tag1            (query_tag1),
        .query_tag2            (query_tag2),
        .ready1                (ready1),
        .ready2                (ready2),
        .value1                (value1),
        .value2                (value2),
        .is_finish_to_rf       (is_finish_to_rf),
        .rd_to_rf              (rd_to_rf),
        .data_to_rf            (data_to_rf),
        .tag_to_rf_commit      (tag_to_rf_commit),
        .is_store_to_slb       (is_store_to_slb),
        .is_exception_to_all   (is_exception_to_all),
        .pc_to_iq              (pc_to_iq)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic offer(input logic [4:0] rd, input logic st);
        is_empty_from_rf = 1'b0;
        rd_from_rf       = rd;
        pc_from_rf       = 32'h100 + {27'd0, rd} * 4;
        is_store_from_rf = st;
    endtask

    task automatic no_offer();
        is_empty_from_rf = 1'b1;
        is_store_from_rf = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data,
                       input logic exc, input logic [31:0] target);
        is_valid_from_cdb     = 1'b1;
        tag_from_cdb          = tag;
        data_from_cdb         = data;
        is_exception_from_cdb = exc;
        target_from_cdb       = target;
    endtask

    task automatic no_cdb();
        is_valid_from_cdb     = 1'b0;
        is_exception_from_cdb = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (tag_to_rf !== 4'd0) $display("FAIL reset_tag: got %0d want 0", tag_to_rf); else n_pass++;
        n_checks++; if (is_full_to_rf !== 1'b0) $display("FAIL reset_full: got %b want 0", is_full_to_rf); else n_pass++;
        n_checks++; if ({is_finish_to_rf, is_store_to_slb, is_exception_to_all} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {is_finish_to_rf, is_store_to_slb, is_exception_to_all}); else n_pass++;
        n_checks++; if (pc_to_iq !== 32'd0) $display("FAIL reset_pc: got %h want 0", pc_to_iq); else n_pass++;
    endtask

    task automatic test_in_order_retire();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h10; exp_data[1] = 32'h20; exp_data[2] = 32'h30;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            offer(5'(i + 1), 1'b0);
            n_checks++; if (tag_to_rf !== 4'(i)) $display("FAIL alloc_tag%0d: got %0d want %0d", i, tag_to_rf, i); else n_pass++;
            tick();
        end
        no_offer();
        n_checks++; if (tag_to_rf !== 4'd3) $display("FAIL tail_after3: got %0d want 3", tag_to_rf); else n_pass++;
        cdb(4'd2, 32'h30, 1'b0, 32'd0); tick();
        n_checks++; if (is_finish_to_rf !== 1'b0) $display("FAIL ooo_wb_tag2_no_retire: got %b want 0", is_finish_to_rf); else n_pass++;
        cdb(4'd0, 32'h10, 1'b0, 32'd0); tick();
        n_checks++; if (is_finish_to_rf !== 1'b0) $display("FAIL wb_head_latency: got %b want 0", is_finish_to_rf); else n_pass++;
        cdb(4'd1, 32'h20, 1'b0, 32'd0); tick();
        no_cdb();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (is_finish_to_rf !== 1'b1 || rd_to_rf !== 5'(i + 1) || data_to_rf !== exp_data[i] || tag_to_rf_commit !== 4'(i))
                $display("FAIL retire%0d: got fin=%b rd=%0d data=%h tag=%0d want fin=1 rd=%0d data=%h tag=%0d",
                         i, is_finish_to_rf, rd_to_rf, data_to_rf, tag_to_rf_commit, i + 1, exp_data[i], i);
            else n_pass++;
            tick();
        end
        n_checks++; if (is_finish_to_rf !== 1'b0) $display("FAIL retire_idle: got %b want 0", is_finish_to_rf); else n_pass++;
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            offer(5'(i + 1), 1'b0);
            tick();
        end
        n_checks++; if (is_full_to_rf !== 1'b1) $display("FAIL full_after16: got %b want 1", is_full_to_rf); else n_pass++;
        offer(5'd31, 1'b0);
        tick();
        n_checks++; if (tag_to_rf !== 4'd0 || is_full_to_rf !== 1'b1)
            $display("FAIL offer17_ignored: got tag=%0d full=%b want tag=0 full=1", tag_to_rf, is_full_to_rf); else n_pass++;
        cdb(4'd0, 32'h77, 1'b0, 32'd0); tick();
        no_cdb();
        n_checks++; if (is_finish_to_rf !== 1'b0 || is_full_to_rf !== 1'b1)
            $display("FAIL full_wb_edge: got fin=%b full=%b want fin=0 full=1", is_finish_to_rf, is_full_to_rf); else n_pass++;
        tick();
        n_checks++; if (is_finish_to_rf !== 1'b1 || rd_to_rf !== 5'd1 || data_to_rf !== 32'h77 || tag_to_rf_commit !== 4'd0)
            $display("FAIL full_retire0: got fin=%b rd=%0d data=%h tag=%0d want fin=1 rd=1 data=77 tag=0",
                     is_finish_to_rf, rd_to_rf, data_to_rf, tag_to_rf_commit); else n_pass++;
        n_checks++; if (is_full_to_rf !== 1'b0 || tag_to_rf !== 4'd0)
            $display("FAIL full_drop: got full=%b tag=%0d want full=0 tag=0", is_full_to_rf, tag_to_rf); else n_pass++;
        tick();
        no_offer();
        n_checks++; if (is_full_to_rf !== 1'b1 || tag_to_rf !== 4'd1)
            $display("FAIL wrap_dispatch: got full=%b tag=%0d want full=1 tag=1", is_full_to_rf, tag_to_rf); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        offer(5'd5, 1'b0); tick();
        offer(5'd6, 1'b0); tick();
        offer(5'd7, 1'b0); tick();
        no_offer();
        cdb(4'd0, 32'h44, 1'b1, 32'h1000); tick();
        no_cdb();
        offer(5'd9, 1'b0);
        tick();
        no_offer();
        n_checks++; if (is_finish_to_rf !== 1'b1 || rd_to_rf !== 5'd5 || data_to_rf !== 32'h44)
            $display("FAIL flush_retire: got fin=%b rd=%0d data=%h want fin=1 rd=5 data=44", is_finish_to_rf, rd_to_rf, data_to_rf); else n_pass++;
        n_checks++; if (is_exception_to_all !== 1'b1 || pc_to_iq !== 32'h1000)
            $display("FAIL flush_pulse: got exc=%b pc=%h want exc=1 pc=1000", is_exception_to_all, pc_to_iq); else n_pass++;
        n_checks++; if (tag_to_rf !== 4'd0 || is_full_to_rf !== 1'b0)
            $display("FAIL flush_dispatch_dropped: got tag=%0d full=%b want tag=0 full=0", tag_to_rf, is_full_to_rf); else n_pass++;
        // Writebacks to the flushed and dropped entries must not retire anything.
        cdb(4'd0, 32'h99, 1'b0, 32'd0); tick();
        n_checks++; if (is_exception_to_all !== 1'b0 || pc_to_iq !== 32'h1000)
            $display("FAIL flush_pulse_end: got exc=%b pc=%h want exc=0 pc=1000", is_exception_to_all, pc_to_iq); else n_pass++;
        cdb(4'd1, 32'h98, 1'b0, 32'd0); tick();
        no_cdb();
        tick();
        n_checks++; if (is_finish_to_rf !== 1'b0) $display("FAIL flush_no_stale_retire: got %b want 0", is_finish_to_rf); else n_pass++;
    endtask

    task automatic test_store_rd0();
        // Continues from the flushed, empty state: head = tail = 0.
        offer(5'd4, 1'b1); tick();
        offer(5'd0, 1'b0); tick();
        offer(5'd8, 1'b0); tick();
        no_offer();
        cdb(4'd0, 32'h55, 1'b0, 32'd0); tick();
        cdb(4'd1, 32'h66, 1'b0, 32'd0); tick();
        n_checks++; if (is_store_to_slb !== 1'b1 || is_finish_to_rf !== 1'b0 || tag_to_rf_commit !== 4'd0 || data_to_rf !== 32'h55)
            $display("FAIL store_retire: got st=%b fin=%b tag=%0d data=%h want st=1 fin=0 tag=0 data=55",
                     is_store_to_slb, is_finish_to_rf, tag_to_rf_commit, data_to_rf); else n_pass++;
        cdb(4'd2, 32'h88, 1'b0, 32'd0); tick();
        no_cdb();
        n_checks++; if (is_store_to_slb !== 1'b0 || is_finish_to_rf !== 1'b0 || tag_to_rf_commit !== 4'd1 || data_to_rf !== 32'h66)
            $display("FAIL rd0_retire: got st=%b fin=%b tag=%0d data=%h want st=0 fin=0 tag=1 data=66",
                     is_store_to_slb, is_finish_to_rf, tag_to_rf_commit, data_to_rf); else n_pass++;
        tick();
        n_checks++; if (is_finish_to_rf !== 1'b1 || rd_to_rf !== 5'd8 || is_store_to_slb !== 1'b0)
            $display("FAIL after_store_retire: got fin=%b rd=%0d st=%b want fin=1 rd=8 st=0", is_finish_to_rf, rd_to_rf, is_store_to_slb); else n_pass++;
    endtask

    task automatic test_rdy_stall();
        offer(5'd10, 1'b0); tick();
        no_offer();
        rdy = 1'b0;
        cdb(4'd3, 32'h99, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({is_finish_to_rf, is_store_to_slb, is_exception_to_all} !== 3'b000 || data_to_rf !== 32'h88)
                $display("FAIL stall%0d: got pulses=%b data=%h want pulses=000 data=88",
                         i, {is_finish_to_rf, is_store_to_slb, is_exception_to_all}, data_to_rf); else n_pass++;
        end
        rdy = 1'b1;
        tick();
        no_cdb();
        n_checks++; if (is_finish_to_rf !== 1'b0) $display("FAIL stall_release_wb: got %b want 0", is_finish_to_rf); else n_pass++;
        tick();
        n_checks++; if (is_finish_to_rf !== 1'b1 || rd_to_rf !== 5'd10 || data_to_rf !== 32'h99 || tag_to_rf_commit !== 4'd3)
            $display("FAIL stall_retire: got fin=%b rd=%0d data=%h tag=%0d want fin=1 rd=10 data=99 tag=3",
                     is_finish_to_rf, rd_to_rf, data_to_rf, tag_to_rf_commit); else n_pass++;
    endtask

    task automatic test_query();
        offer(5'd11, 1'b0); tick();
        no_offer();
        query_tag1 = 4'd4;
        query_tag2 = 4'd3;
        #1;
        n_checks++; if (ready1 !== 1'b0) $display("FAIL query_pending: got %b want 0", ready1); else n_pass++;
        n_checks++; if (ready2 !== 1'b0) $display("FAIL query_retired: got %b want 0", ready2); else n_pass++;
        cdb(4'd4, 32'hDEAD, 1'b0, 32'd0); tick();
        no_cdb();
        n_checks++; if (ready1 !== 1'b1 || value1 !== 32'hDEAD)
            $display("FAIL query_ready: got rdy=%b val=%h want rdy=1 val=dead", ready1, value1); else n_pass++;
        tick();
        n_checks++; if (is_finish_to_rf !== 1'b1 || rd_to_rf !== 5'd11 || ready1 !== 1'b0)
            $display("FAIL query_after_retire: got fin=%b rd=%0d rdy=%b want fin=1 rd=11 rdy=0", is_finish_to_rf, rd_to_rf, ready1); else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        is_empty_from_rf = 1'b1;
        rd_from_rf = '0;
        pc_from_rf = '0;
        is_store_from_rf = 1'b0;
        is_valid_from_cdb = 1'b0;
        tag_from_cdb = '0;
        data_from_cdb = '0;
        is_exception_from_cdb = 1'b0;
        target_from_cdb = '0;
        query_tag1 = '0;
        query_tag2 = '0;
        #2;
        test_reset();
        test_in_order_retire();
        test_full_wrap();
        test_flush();
        test_store_rd0();
        test_rdy_stall();
        test_query();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
